// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues single-outstanding word reads to
// instruction memory and feeds decode through an IF/ID register backed by a one-entry buffer.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    state_t            state_r, state_nxt_s;
    logic [XLEN-1:0]   fetch_pc_r, fetch_pc_nxt_s;
    logic              squash_r, squash_nxt_s;
    logic              fault_r, fault_nxt_s;
    logic              out_valid_r, out_valid_nxt_s;
    logic [31:0]       out_instr_r, out_instr_nxt_s;
    logic [XLEN-1:0]   out_pc_r, out_pc_nxt_s;
    logic [XLEN-1:0]   out_pc4_r, out_pc4_nxt_s;
    logic              buf_valid_r, buf_valid_nxt_s;
    logic [31:0]       buf_instr_r, buf_instr_nxt_s;
    logic [XLEN-1:0]   buf_pc_r, buf_pc_nxt_s;
    logic [XLEN-1:0]   buf_pc4_r, buf_pc4_nxt_s;

    logic              accept_s, redirect_s, req_fire_s, rsp_take_s, deliver_s;
    logic              misaligned_s;
    logic [XLEN-1:0]   rsp_pc4_s;

    assign imem_req_valid = (state_r == S_REQ) && !buf_valid_r;
    assign imem_req_addr  = fetch_pc_r;
    assign instr_valid    = out_valid_r;
    assign Instr          = out_instr_r;
    assign PC             = out_pc_r;
    assign PCPlus4        = out_pc4_r;
    assign fetch_fault    = fault_r;

    // Next-state logic for the fetch FSM, PC, squash flag and the out/buf datapath
    always_comb begin
        state_nxt_s     = state_r;
        fetch_pc_nxt_s  = fetch_pc_r;
        squash_nxt_s    = squash_r;
        fault_nxt_s     = fault_r;
        out_valid_nxt_s = out_valid_r;
        out_instr_nxt_s = out_instr_r;
        out_pc_nxt_s    = out_pc_r;
        out_pc4_nxt_s   = out_pc4_r;
        buf_valid_nxt_s = buf_valid_r;
        buf_instr_nxt_s = buf_instr_r;
        buf_pc_nxt_s    = buf_pc_r;
        buf_pc4_nxt_s   = buf_pc4_r;

        accept_s     = out_valid_r && instr_ready;
        redirect_s   = accept_s && PCSrc;
        req_fire_s   = imem_req_valid && imem_req_ready;
        rsp_take_s   = (state_r == S_WAIT) && imem_rsp_valid;
        deliver_s    = rsp_take_s && !squash_r && !redirect_s;
        misaligned_s = (PCTarget[1:0] != 2'b00);
        rsp_pc4_s    = fetch_pc_r + PC_STEP;

        case (state_r)
            S_REQ: begin
                if (req_fire_s) state_nxt_s = S_WAIT;
                else            state_nxt_s = S_REQ;
            end
            S_WAIT: begin
                if (rsp_take_s) begin
                    state_nxt_s  = S_REQ;
                    squash_nxt_s = 1'b0;
                end else begin
                    state_nxt_s  = S_WAIT;
                end
            end
            S_FAULT: state_nxt_s = S_FAULT;
            default: begin
                state_nxt_s = S_FAULT;
                fault_nxt_s = 1'b1;
            end
        endcase

        // A request accepted this cycle still carries the pre-redirect address
        if (redirect_s) begin
            fetch_pc_nxt_s = PCTarget;
            squash_nxt_s   = ((state_r == S_WAIT) && !imem_rsp_valid) || req_fire_s;
            if (misaligned_s) begin
                state_nxt_s = S_FAULT;
                fault_nxt_s = 1'b1;
            end else begin
                fault_nxt_s = fault_r;
            end
        end else if (deliver_s) begin
            fetch_pc_nxt_s = rsp_pc4_s;
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end

        if (redirect_s) begin
            out_valid_nxt_s = 1'b0;
            buf_valid_nxt_s = 1'b0;
        end else if (accept_s) begin
            if (buf_valid_r) begin
                out_instr_nxt_s = buf_instr_r;
                out_pc_nxt_s    = buf_pc_r;
                out_pc4_nxt_s   = buf_pc4_r;
                buf_valid_nxt_s = deliver_s;
                buf_instr_nxt_s = imem_rsp_data;
                buf_pc_nxt_s    = fetch_pc_r;
                buf_pc4_nxt_s   = rsp_pc4_s;
            end else if (deliver_s) begin
                out_instr_nxt_s = imem_rsp_data;
                out_pc_nxt_s    = fetch_pc_r;
                out_pc4_nxt_s   = rsp_pc4_s;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else if (deliver_s) begin
            if (!out_valid_r) begin
                out_valid_nxt_s = 1'b1;
                out_instr_nxt_s = imem_rsp_data;
                out_pc_nxt_s    = fetch_pc_r;
                out_pc4_nxt_s   = rsp_pc4_s;
            end else begin
                buf_valid_nxt_s = 1'b1;
                buf_instr_nxt_s = imem_rsp_data;
                buf_pc_nxt_s    = fetch_pc_r;
                buf_pc4_nxt_s   = rsp_pc4_s;
            end
        end else begin
            out_valid_nxt_s = out_valid_r;
        end

        if (state_r == S_FAULT) begin
            out_valid_nxt_s = 1'b0;
            buf_valid_nxt_s = 1'b0;
        end else begin
            fault_nxt_s = fault_nxt_s;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_REQ;
            fetch_pc_r  <= RESET_PC;
            squash_r    <= 1'b0;
            fault_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_instr_r <= NOP_INSTR;
            out_pc_r    <= '0;
            out_pc4_r   <= '0;
            buf_valid_r <= 1'b0;
            buf_instr_r <= 32'h0000_0000;
            buf_pc_r    <= '0;
            buf_pc4_r   <= '0;
        end else begin
            state_r     <= state_nxt_s;
            fetch_pc_r  <= fetch_pc_nxt_s;
            squash_r    <= squash_nxt_s;
            fault_r     <= fault_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_instr_r <= out_instr_nxt_s;
            out_pc_r    <= out_pc_nxt_s;
            out_pc4_r   <= out_pc4_nxt_s;
            buf_valid_r <= buf_valid_nxt_s;
            buf_instr_r <= buf_instr_nxt_s;
            buf_pc_r    <= buf_pc_nxt_s;
            buf_pc4_r   <= buf_pc4_nxt_s;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected instructions and
// request addresses; negedge monitors pop and compare as the DUT presents them.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0000_0000;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = 32'h0000_0000;
    logic        fetch_fault;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
    typedef struct { logic [31:0] data; int due; } mem_t;

    exp_t        exp_q[$];
    logic [31:0] req_q[$];
    mem_t        mq[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          fire_cnt = 0;
    int          fc0;
    logic [31:0] data_xor = 32'h0000_0000;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(mem_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
        .PCSrc(PCSrc), .PCTarget(PCTarget), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: fixed latency, data = addr ^ data_xor captured at handshake
    always @(negedge clk) begin
        imem_rsp_valid = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].data;
            void'(mq.pop_front());
        end
        if (rst_n === 1'b1 && imem_req_valid === 1'b1 && mem_ready === 1'b1) begin
            fire_cnt++;
            mq.push_back('{imem_req_addr ^ data_xor, cyc + lat});
            if (req_q.size() > 0) chk("req_addr", imem_req_addr, req_q.pop_front());
        end
    end

    // Instruction monitor: every accepted instruction must match the next expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_instr: got PC %h Instr %h, expected none", PC, Instr);
            end else begin
                e = exp_q.pop_front();
                chk("instr", Instr, e.instr);
                chk("pc", PC, e.pc);
                chk("pcplus4", PCPlus4, e.pc + 32'd4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_i(input logic [31:0] pc);
        exp_q.push_back('{pc ^ data_xor, pc});
    endtask

    task automatic do_reset(input int l, input logic [31:0] x);
        rst_n = 1'b0; instr_ready = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0000_0000;
        mem_ready = 1'b1; lat = l; data_xor = x;
        tick();
        tick();
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_pc", PC, 32'h0000_0000);
        chk("rst_pcplus4", PCPlus4, 32'h0000_0000);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        mq.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_pc(input logic [31:0] p);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (instr_valid === 1'b1 && PC === p) found = 1'b1;
        end
        chk("wait_pc", {31'd0, found}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
        instr_ready = 1'b0;
        chk("drain_instr", exp_q.size(), 32'd0);
        chk("drain_req", req_q.size(), 32'd0);
        exp_q.delete();
        req_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential fetch, first-fetch timing and 1-per-2-cycles throughput
        do_reset(1, 32'h0000_0000);
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_i(32'(k * 4));
            req_q.push_back(32'(k * 4));
        end
        chk("c0_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("c0_req_addr", imem_req_addr, 32'h0000_0000);
        tick(); chk("c1_valid", {31'd0, instr_valid}, 32'd0);
        tick(); chk("c2_valid", {31'd0, instr_valid}, 32'd1);
        chk("c2_pc", PC, 32'h0000_0000);
        tick(); chk("c3_valid", {31'd0, instr_valid}, 32'd0);
        tick(); chk("c4_valid", {31'd0, instr_valid}, 32'd1);
        drain();

        // Backpressure: out + buf fill, then requests stop
        do_reset(1, 32'hCAFE_0000);
        fc0 = fire_cnt;
        push_i(32'h0); push_i(32'h4); push_i(32'h8);
        req_q.push_back(32'h0); req_q.push_back(32'h4); req_q.push_back(32'h8);
        tick(); tick();
        chk("bp_first_valid", {31'd0, instr_valid}, 32'd1);
        for (int k = 0; k < 9; k++) tick();
        chk("bp_fire_count", fire_cnt - fc0, 32'd2);
        chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
        tick(); instr_ready = 1'b1;
        tick();
        chk("bp_no_gap_valid", {31'd0, instr_valid}, 32'd1);
        chk("bp_no_gap_pc", PC, 32'h0000_0004);
        drain();

        // Redirect while the 0xC request is outstanding
        do_reset(3, 32'hDEAD_0000);
        push_i(32'h0); push_i(32'h4); push_i(32'h8); push_i(32'h40); push_i(32'h44);
        req_q.push_back(32'h0); req_q.push_back(32'h4); req_q.push_back(32'h8);
        req_q.push_back(32'hC); req_q.push_back(32'h40); req_q.push_back(32'h44);
        instr_ready = 1'b1;
        wait_pc(32'h8);
        instr_ready = 1'b0;
        tick();
        instr_ready = 1'b1; PCSrc = 1'b1; PCTarget = 32'h0000_0040;
        tick();
        PCSrc = 1'b0;
        drain();

        // Request-channel stall holds the address
        do_reset(1, 32'h0BAD_0000);
        mem_ready = 1'b0;
        push_i(32'h0); push_i(32'h4);
        req_q.push_back(32'h0); req_q.push_back(32'h4);
        instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("stall_req_addr", imem_req_addr, 32'h0000_0000);
            tick();
        end
        mem_ready = 1'b1;
        drain();

        // Misaligned redirect target: sticky fault, no more requests
        do_reset(1, 32'h0000_0000);
        push_i(32'h0);
        req_q.push_back(32'h0); req_q.push_back(32'h4);
        instr_ready = 1'b1;
        wait_pc(32'h0);
        PCSrc = 1'b1; PCTarget = 32'h0000_0042;
        tick();
        PCSrc = 1'b0;
        chk("fault_set", {31'd0, fetch_fault}, 32'd1);
        chk("fault_valid", {31'd0, instr_valid}, 32'd0);
        fc0 = fire_cnt;
        for (int k = 0; k < 20; k++) tick();
        chk("fault_no_req", fire_cnt - fc0, 32'd0);
        chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
        chk("fault_req_valid", {31'd0, imem_req_valid}, 32'd0);
        drain();
        do_reset(1, 32'h0000_0000);
        push_i(32'h0);
        instr_ready = 1'b1;
        drain();

        // Reset while waiting; the stale response lands in the first cycle after release
        do_reset(2, 32'h1234_0000);
        tick();
        rst_n = 1'b0;
        data_xor = 32'h5678_0000;
        tick();
        rst_n = 1'b1;
        push_i(32'h0);
        instr_ready = 1'b1;
        tick();
        chk("stale_ignored", {31'd0, instr_valid}, 32'd0);
        drain();

        // PCPlus4 wraps at the top of the address space
        do_reset(1, 32'h0F0F_0000);
        push_i(32'h0); push_i(32'hFFFF_FFFC); push_i(32'h0);
        req_q.push_back(32'h0); req_q.push_back(32'h4);
        req_q.push_back(32'hFFFF_FFFC); req_q.push_back(32'h0);
        instr_ready = 1'b1;
        wait_pc(32'h0);
        PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFC;
        tick();
        PCSrc = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit and decode.
- Holds the PC and issues word reads to instruction memory over a valid/ready request channel with a single outstanding request.
- Presents fetched Instr/PC/PCPlus4 to decode through an IF/ID output register with a valid/ready handshake.
- Consumes the control unit's PCSrc and the computed PCTarget to redirect fetch, squashing wrong-path work.

Parameters:
- XLEN, 32, address/data width; only 32 is supported.
- RESET_PC, 32'h0000_0000, first fetch address; must be a multiple of 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  word address of the request.
- imem_rsp_valid  input  1  read data valid; never backpressured; at least 1 cycle after acceptance.
- imem_rsp_data  input  32  read data.
- instr_valid  output  1  IF/ID register holds an instruction.
- instr_ready  input  1  decode accepts the instruction this cycle.
- Instr  output  32  instruction word.
- PC  output  XLEN  address of Instr.
- PCPlus4  output  XLEN  PC+4.
- PCSrc  input  1  redirect request; sampled only on accept (instr_valid & instr_ready).
- PCTarget  input  XLEN  redirect address.
- fetch_fault  output  1  sticky misaligned-target flag.

Behaviour:
- Reset (rst_n=0 at edge): fetch_pc=RESET_PC; state=S_REQ; instr_valid=0; buffer empty; squash=0; fetch_fault=0; Instr=32'h0000_0013; PC=0; PCPlus4=0.
- Storage:
  - Output register (out).
  - One-entry response buffer (buf).
  - fetch_pc.
  - squash flag.
  - At most one request outstanding.
- States:
  - S_REQ: imem_req_valid = !buf_valid and imem_req_addr = fetch_pc, both combinational from registers. Handshake completes → S_WAIT. Address holds stable while ready is low.
  - S_WAIT: waiting for a response. On imem_rsp_valid:
    - If squash=1: discard the data, clear squash, go to S_REQ.
    - Else: deliver the word (see Delivery), fetch_pc += 4, go to S_REQ.
  - S_FAULT: imem_req_valid=0; responses discarded; instr_valid=0; exit only by reset.
- imem_rsp_valid outside S_WAIT is ignored. This covers stale responses after reset.
- Delivery of a non-squashed response with address a, in priority order:
  - out empty, or out accepted this cycle without redirect: out ← {rsp, a, a+4}.
  - Otherwise: buf ← {rsp, a, a+4}.
- Accept without redirect (instr_valid & instr_ready & !PCSrc), out refill in priority order:
  - From buf if buf valid.
  - Else from the same-cycle response.
  - Else instr_valid=0.
- Accept with redirect (instr_valid & instr_ready & PCSrc):
  - out invalidated; buf invalidated.
  - A same-cycle response is discarded.
  - fetch_pc ← PCTarget.
  - squash ← 1 if a request is outstanding, or if a request handshake completes this same cycle (it carries the stale address).
  - If PCTarget[1:0] != 0: state ← S_FAULT and fetch_fault ← 1 next cycle. No request is ever issued to the misaligned address.
- Ordering: instructions reach decode in program order with no duplicates and no drops. PCPlus4 = PC+4 mod 2^32; 32'hFFFF_FFFC wraps to 0.
- Throughput with zero-wait memory and instr_ready=1 is one instruction per 2 cycles.
- First-fetch timing:
  - Request in the first cycle after rst_n rises (cycle 0).
  - Response in cycle 1.
  - instr_valid=1 in cycle 2.
- Backpressure: at most 2 fetched words are held (out + buf). Requests stop while buf is full.
- Reset mid-operation: all state returns to reset values regardless of state. Fetch restarts at RESET_PC.

Test Plan:
- Sequential fetch: RESET_PC=0, zero-wait memory returning data = address, instr_ready=1 → instr_valid first at cycle 2, then every 2 cycles; PC 0,4,8,12; PCPlus4 4,8,12,16; Instr equals PC.
- Backpressure: instr_ready=0 for 10 cycles after first valid → exactly 2 requests (0x0, 0x4), then imem_req_valid=0; release → PC 0,4,8 with no gap, loss or repeat.
- Redirect with in-flight fetch: accept PC=0x8 with PCSrc=1, PCTarget=0x40 while request 0xC is outstanding → 0xC data never appears on Instr; next request address 0x40; next instr_valid has PC=0x40.
- Request stall: imem_req_ready=0 for 5 cycles → imem_req_addr holds 0x0 and imem_req_valid stays 1; on ready=1 fetch proceeds normally.
- Misaligned redirect: accept with PCSrc=1, PCTarget=0x42 → fetch_fault=1 next cycle; instr_valid=0; no further requests for 20 cycles; reset clears fetch_fault and refetches RESET_PC.
- Reset in S_WAIT: rst_n=0 for 1 cycle while a request is outstanding, stale response arrives the cycle after release → response ignored; first instr_valid shows PC=RESET_PC with the correct word.
